// File: rtl/dcfeb_jtag_pkg.sv
// -----------------------------------------------------------------------------
// dcfeb_jtag_pkg
// Shared JTAG user-chain definitions for the DCFEB slow-control path.
// Holds the default instruction-register length, the reset/TLR instruction
// and the named function codes. The USER1 decoder (user_instr_dcd) and the
// USER2 user_cap_reg instantiation sites both refer to these codes, so a
// function strobe F[FN_x] always lines up with the data register it selects.
// -----------------------------------------------------------------------------
package dcfeb_jtag_pkg;

  // Default USER1 instruction length in bits.
  localparam int IR_WIDTH_DEF = 8;

  // Named function codes carried in the USER1 instruction register.
  typedef enum logic [7:0] {
    FN_NOP        = 8'h00,  // no operation; selected after reset / TLR
    FN_RD_ID      = 8'h01,  // read board identification word
    FN_WR_CFG     = 8'h02,  // write configuration register
    FN_RD_CFG     = 8'h03,  // read back configuration register
    FN_RD_STATUS  = 8'h04,  // read status word
    FN_CAP_ADC    = 8'h10,  // capture ADC snapshot
    FN_RD_ADC     = 8'h11,  // read ADC snapshot
    FN_WR_DAC     = 8'h20,  // load calibration DAC
    FN_BYPASS     = 8'hFF   // reserved / bypass
  } dcfeb_fn_e;

  // Instruction loaded on reset and on Test-Logic-Reset.
  localparam logic [7:0] DEFAULT_INSTR_DEF = FN_NOP;

endpackage : dcfeb_jtag_pkg

// File: rtl/onehot_dcd.sv
// -----------------------------------------------------------------------------
// onehot_dcd
// Purely combinational binary-to-one-hot decoder.
// Ports:
//   bin     in   WIDTH       binary code
//   onehot  out  2**WIDTH    onehot[bin] = 1, all other bits 0
// -----------------------------------------------------------------------------
module onehot_dcd #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]      bin,
  output logic [2**WIDTH-1:0]   onehot
);

  // Decode: clear every strobe, then raise the one addressed by bin.
  always_comb begin
    onehot      = {(2**WIDTH){1'b0}};
    onehot[bin] = 1'b1;
  end

endmodule : onehot_dcd

// File: rtl/user_instr_dcd.sv
// -----------------------------------------------------------------------------
// user_instr_dcd
// JTAG user-instruction register and function decoder on the USER1 BSCAN
// chain. A function code is shifted in LSB first and is only accepted on
// Update-DR when exactly IR_WIDTH bits were shifted since the last
// Capture/Update/TLR/RST; otherwise the instruction holds and LEN_ERR flags
// the rejected update. Capture-DR reloads the current instruction into the
// shift register so software can read it back on TDO.
// F carries a one-hot strobe per function code, registered from IR.
//
// Ports:
//   DRCK     in   1             JTAG data clock (sole clock)
//   RST      in   1             synchronous active-high reset
//   SEL      in   1             USER1 selected
//   TDI      in   1             serial data in
//   SHIFT    in   1             TAP in Shift-DR
//   CAPTURE  in   1             TAP in Capture-DR
//   UPDATE   in   1             TAP in Update-DR (level sampled on DRCK)
//   TLR      in   1             TAP in Test-Logic-Reset; forces DEFAULT_INSTR
//   TDO      out  1             serial data out, SEL & sr[0]
//   IR       out  IR_WIDTH      latched instruction
//   F        out  2**IR_WIDTH   one-hot function strobes, F[IR] = 1
//   LEN_ERR  out  1             last UPDATE rejected on bit-count mismatch
// -----------------------------------------------------------------------------
module user_instr_dcd
  import dcfeb_jtag_pkg::*;
#(
  parameter int                 IR_WIDTH      = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] DEFAULT_INSTR = IR_WIDTH'(DEFAULT_INSTR_DEF)
) (
  input  logic                    DRCK,
  input  logic                    RST,
  input  logic                    SEL,
  input  logic                    TDI,
  input  logic                    SHIFT,
  input  logic                    CAPTURE,
  input  logic                    UPDATE,
  input  logic                    TLR,
  output logic                    TDO,
  output logic [IR_WIDTH-1:0]     IR,
  output logic [2**IR_WIDTH-1:0]  F,
  output logic                    LEN_ERR
);

  // Counter must hold IR_WIDTH+1 so an overshift stays distinguishable
  // from an exact-length shift.
  localparam int              CW       = $clog2(IR_WIDTH + 2);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_FULL = CW'(IR_WIDTH);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(IR_WIDTH + 1);

  logic [IR_WIDTH-1:0]     sr_r,      sr_nxt_s;
  logic [IR_WIDTH-1:0]     ir_r,      ir_nxt_s;
  logic [CW-1:0]           cnt_r,     cnt_nxt_s;
  logic                    len_err_r, len_err_nxt_s;
  logic [2**IR_WIDTH-1:0]  f_r;
  logic [2**IR_WIDTH-1:0]  dcd_s;

  // Saturating bit counter increment: once past IR_WIDTH it sticks at
  // IR_WIDTH+1 so any overshift is rejected at the next update.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    if (c >= CNT_SAT) begin
      r = CNT_SAT;
    end else begin
      r = c + CW'(1);
    end
    return r;
  endfunction

  onehot_dcd #(
    .WIDTH (IR_WIDTH)
  ) u_onehot_dcd (
    .bin    (ir_r),
    .onehot (dcd_s)
  );

  // Next-state selection; TLR outranks all TAP states and ignores SEL.
  always_comb begin
    sr_nxt_s      = sr_r;
    ir_nxt_s      = ir_r;
    cnt_nxt_s     = cnt_r;
    len_err_nxt_s = len_err_r;
    if (TLR) begin
      // Partial shift is discarded by zeroing the count; sr is left alone.
      ir_nxt_s      = DEFAULT_INSTR;
      cnt_nxt_s     = CNT_ZERO;
      len_err_nxt_s = 1'b0;
    end else if (SEL && UPDATE) begin
      if (cnt_r == CNT_FULL) begin
        ir_nxt_s      = sr_r;
        len_err_nxt_s = 1'b0;
      end else begin
        len_err_nxt_s = 1'b1;
      end
      cnt_nxt_s = CNT_ZERO;
    end else if (SEL && CAPTURE) begin
      sr_nxt_s  = ir_r;
      cnt_nxt_s = CNT_ZERO;
    end else if (SEL && SHIFT) begin
      sr_nxt_s  = {TDI, sr_r[IR_WIDTH-1:1]};
      cnt_nxt_s = cnt_inc(cnt_r);
    end else begin
      // Deselected or idle TAP state: hold everything.
      sr_nxt_s = sr_r;
    end
  end

  // Instruction-path state registers with synchronous reset.
  always_ff @(posedge DRCK) begin
    if (RST) begin
      sr_r      <= {IR_WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      ir_r      <= DEFAULT_INSTR;
      len_err_r <= 1'b0;
    end else begin
      sr_r      <= sr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ir_r      <= ir_nxt_s;
      len_err_r <= len_err_nxt_s;
    end
  end

  // Function strobes follow IR one DRCK later; no reset needed because the
  // decoder output is one-hot by construction once IR is defined.
  always_ff @(posedge DRCK) begin
    f_r <= dcd_s;
  end

  assign TDO     = SEL & sr_r[0];
  assign IR      = ir_r;
  assign F       = f_r;
  assign LEN_ERR = len_err_r;

endmodule : user_instr_dcd
